// File: rtl/sync_reset_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : sync_reset_delay_line
// Purpose  : WIDTH-bit, DEPTH-stage clock-enabled delay line with per-stage
//            valid tracking, run-time selectable output tap, flush and a
//            saturating fill counter. Reset is synchronous and active high.
// Ports    : clk         - rising-edge clock
//            reset       - synchronous active-high reset
//            en          - shift enable (low freezes all state)
//            flush       - clears valid bits and fill counter, data holds
//            d_in        - input data, qualified by d_in_valid
//            d_in_valid  - valid bit entering stage 0
//            dly_sel     - selected delay 1..DEPTH (0 -> 1, >DEPTH -> DEPTH)
//            d_out       - data at selected tap
//            d_out_valid - valid bit at selected tap
//            fill_cnt    - enabled shifts since reset/flush, saturates at DEPTH
//            full        - fill_cnt == DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module sync_reset_delay_line #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_in_valid,
    input  logic [SEL_W-1:0] dly_sel,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_valid,
    output logic [SEL_W-1:0] fill_cnt,
    output logic             full
);

    localparam logic [SEL_W-1:0] c_depth = SEL_W'(DEPTH);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [SEL_W-1:0] r_fill_cnt;
    logic [SEL_W-1:0] w_tap;

    // Stage 0 takes the input; every later stage takes its predecessor.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[gi]  <= RESET_VAL;
                    r_valid[gi] <= 1'b0;
                end else if (flush) begin
                    r_valid[gi] <= 1'b0;
                end else if (en) begin
                    if (gi == 0) begin
                        r_data[gi]  <= d_in;
                        r_valid[gi] <= d_in_valid;
                    end else begin
                        r_data[gi]  <= r_data[(gi == 0) ? 0 : gi - 1];
                        r_valid[gi] <= r_valid[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_fill_cnt <= '0;
        end else if (en && (r_fill_cnt != c_depth)) begin
            r_fill_cnt <= r_fill_cnt + SEL_W'(1);
        end
    end

    // Zero-based tap index, clamped into the implemented stage range.
    always_comb begin
        w_tap = '0;
        if (dly_sel == '0) begin
            w_tap = '0;
        end else if (dly_sel > c_depth) begin
            w_tap = c_depth - SEL_W'(1);
        end else begin
            w_tap = dly_sel - SEL_W'(1);
        end
    end

    // Compare-based mux keeps the index width independent of DEPTH.
    always_comb begin
        d_out       = r_data[0];
        d_out_valid = r_valid[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_tap == SEL_W'(i)) begin
                d_out       = r_data[i];
                d_out_valid = r_valid[i];
            end
        end
    end

    assign fill_cnt = r_fill_cnt;
    assign full     = (r_fill_cnt == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_sync_reset_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_reset_delay_line
// Purpose  : Directed self-checking bench for sync_reset_delay_line
//            (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_reset_delay_line;

    localparam int c_width = 8;
    localparam int c_depth = 4;
    localparam int c_sel_w = $clog2(c_depth + 1);

    logic               clk;
    logic               reset;
    logic               en;
    logic               flush;
    logic [c_width-1:0] d_in;
    logic               d_in_valid;
    logic [c_sel_w-1:0] dly_sel;
    logic [c_width-1:0] d_out;
    logic               d_out_valid;
    logic [c_sel_w-1:0] fill_cnt;
    logic               full;

    int n_checks = 0;
    int n_errors = 0;

    sync_reset_delay_line #(
        .WIDTH     (c_width),
        .DEPTH     (c_depth),
        .RESET_VAL (8'hA5)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .d_in        (d_in),
        .d_in_valid  (d_in_valid),
        .dly_sel     (dly_sel),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .fill_cnt    (fill_cnt),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] data);
        en = 1'b1; d_in = data; d_in_valid = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0;
        d_in = '0; d_in_valid = 1'b0; dly_sel = 3'd4;
        tick();
        reset = 1'b0;

        // Traffic, then reset held for two edges
        push(8'h3C); push(8'h7E); push(8'h99);
        reset = 1'b1; d_in = 8'hC3;
        tick(); tick();
        check("rst_dout", 32'(d_out), 'hA5);
        check("rst_valid", 32'(d_out_valid), 0);
        check("rst_fill", 32'(fill_cnt), 0);
        check("rst_full", 32'(full), 0);
        dly_sel = 3'd1; #1;
        check("rst_dout_tap1", 32'(d_out), 'hA5);
        reset = 1'b0;

        // Short reset pulse between edges must not act until an edge
        push(8'h42);
        check("pre_pulse_dout", 32'(d_out), 'h42);
        en = 1'b0;
        #1 reset = 1'b1;
        #3 reset = 1'b0;
        check("pulse_no_async", 32'(d_out), 'h42);
        tick();
        check("pulse_after_edge", 32'(d_out), 'h42);
        check("pulse_fill", 32'(fill_cnt), 1);

        // Full-depth latency and fill counter saturation
        flush = 1'b1; tick(); flush = 1'b0;
        dly_sel = 3'd4;
        push(8'h01);
        check("lat_fill1", 32'(fill_cnt), 1);
        check("lat_valid1", 32'(d_out_valid), 0);
        push(8'h02);
        check("lat_fill2", 32'(fill_cnt), 2);
        push(8'h03);
        check("lat_fill3", 32'(fill_cnt), 3);
        check("lat_full3", 32'(full), 0);
        check("lat_valid3", 32'(d_out_valid), 0);
        push(8'h04);
        check("lat_fill4", 32'(fill_cnt), 4);
        check("lat_full4", 32'(full), 1);
        check("lat_dout4", 32'(d_out), 'h01);
        check("lat_valid4", 32'(d_out_valid), 1);
        push(8'h05);
        check("lat_fill5_sat", 32'(fill_cnt), 4);
        check("lat_full5", 32'(full), 1);
        check("lat_dout5", 32'(d_out), 'h02);

        // Tap select and clamping, no clock edge in between
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        en = 1'b0;
        dly_sel = 3'd1; #1; check("tap1", 32'(d_out), 'h13);
        dly_sel = 3'd3; #1; check("tap3", 32'(d_out), 'h11);
        dly_sel = 3'd0; #1; check("tap0_clamp", 32'(d_out), 'h13);
        dly_sel = 3'd7; #1; check("tap7_clamp", 32'(d_out), 'h10);
        dly_sel = 3'd2; d_in = 8'hEE; #1; check("tap2_no_din_path", 32'(d_out), 'h12);

        // Flush together with enable: flush wins, nothing captured
        en = 1'b1; flush = 1'b1; d_in = 8'hFF; d_in_valid = 1'b1;
        tick();
        flush = 1'b0; en = 1'b0;
        check("flush_fill", 32'(fill_cnt), 0);
        check("flush_full", 32'(full), 0);
        dly_sel = 3'd1; #1;
        check("flush_valid", 32'(d_out_valid), 0);
        check("flush_data_s0", 32'(d_out), 'h13);
        dly_sel = 3'd4; #1;
        check("flush_data_s3", 32'(d_out), 'h10);

        // Enable gating: 1,0,0,1
        dly_sel = 3'd2;
        push(8'h55);
        check("gate_fill_e1", 32'(fill_cnt), 1);
        check("gate_dout_e1", 32'(d_out), 'h13);
        check("gate_valid_e1", 32'(d_out_valid), 0);
        en = 1'b0; d_in = 8'h66;
        tick();
        check("gate_frozen1", 32'(d_out), 'h13);
        check("gate_fill_d1", 32'(fill_cnt), 1);
        tick();
        check("gate_frozen2", 32'(d_out), 'h13);
        check("gate_fill_d2", 32'(fill_cnt), 1);
        push(8'h66);
        check("gate_dout_e2", 32'(d_out), 'h55);
        check("gate_valid_e2", 32'(d_out_valid), 1);
        check("gate_fill_e2", 32'(fill_cnt), 2);

        // Reset and flush together mid-stream, then resume traffic
        push(8'h70);
        en = 1'b1; d_in = 8'h77; reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        for (int i = 1; i <= c_depth; i++) begin
            dly_sel = 3'(i); #1;
            check($sformatf("rf_dout_tap%0d", i), 32'(d_out), 'hA5);
            check($sformatf("rf_valid_tap%0d", i), 32'(d_out_valid), 0);
        end
        check("rf_fill", 32'(fill_cnt), 0);
        dly_sel = 3'd3;
        push(8'h81);
        check("resume_valid1", 32'(d_out_valid), 0);
        push(8'h82);
        check("resume_dout2", 32'(d_out), 'hA5);
        check("resume_valid2", 32'(d_out_valid), 0);
        push(8'h83);
        check("resume_dout3", 32'(d_out), 'h81);
        check("resume_valid3", 32'(d_out_valid), 1);
        check("resume_fill3", 32'(fill_cnt), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
